scs8hd_bufinv_rx: RTL and testbench

Clocked receiver for a level signal driven across the block through inverting scs8hd buffer chains (the bufinv drive end). It synchronizes the asynchronous line, undoes the line inversion and rejects short glitches. It presents a clean level, one-cycle edge pulses and a wrapping edge counter to the clocked logic downstream.

---
 rtl/scs8hd_bufinv_rx_if.sv | 27 ++
 rtl/scs8hd_bufinv_rx.sv | 154 +++++++++++++++
 tb/tb_scs8hd_bufinv_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/scs8hd_bufinv_rx_if.sv
// scs8hd_bufinv_rx_if: bundle between the bufinv line receiver and its consumer.
// Handshake: there is no valid/ready pair and no backpressure. A is a free-running
// asynchronous level. X is a registered level. RISE, FALL and GLITCH are registered
// single-cycle qualifiers: each is valid for exactly the one cycle in which it is high.
// CNT is a registered count that is always valid.
interface scs8hd_bufinv_rx_if #(
  parameter int CW = 8
);
  logic          A;
  logic          X;
  logic          RISE;
  logic          FALL;
  logic          GLITCH;
  logic [CW-1:0] CNT;

  // Receiver side
  modport slave (
    input  A,
    output X, RISE, FALL, GLITCH, CNT
  );

  // Line driver / consumer side
  modport master (
    output A,
    input  X, RISE, FALL, GLITCH, CNT
  );
endinterface

// File: rtl/scs8hd_bufinv_rx.sv
// scs8hd_bufinv_rx: synchronizes an inverted level line, removes the inversion,
// optionally filters short glitches and reports edges plus a wrapping edge count.
// Build option: define SCS8HD_BUFINV_RX_FILTER_EN to build the qualification filter
// (QUAL state and q counter). Without it every new synchronized level is accepted
// immediately and GLITCH is tied low.
module scs8hd_bufinv_rx #(
  parameter int SYNC_STAGES = 2,  // 2..4
  parameter int FILT_CYCLES = 4,  // 1..15
  parameter int CW          = 8,
  parameter int INVERT      = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  scs8hd_bufinv_rx_if.slave        bus,
  output logic [1:0]               state_o
);

  localparam logic       INV       = (INVERT != 0);
  localparam logic [1:0] INIT_LAST = 2'(SYNC_STAGES - 1);

`ifdef SCS8HD_BUFINV_RX_FILTER_EN
  localparam logic [3:0] FILT_Q = 4'(FILT_CYCLES);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_QUAL   = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_STABLE = 2'd1
  } state_e;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d;
  logic                   d_next;

  state_e                 state_q;
  logic   [1:0]           init_q;
  logic                   x_q;
  logic                   rise_q;
  logic                   fall_q;
  logic   [CW-1:0]        cnt_q;
`ifdef SCS8HD_BUFINV_RX_FILTER_EN
  logic                   glitch_q;
  logic   [3:0]           q_q;
`endif

  // Synchronizer chain on the asynchronous line, cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.A};
    end
  end

  // d is the de-inverted level the FSM acts on. d_next is the value the last
  // stage takes at this edge; INIT loads X from it so that a line already at its
  // active level when reset releases is absorbed instead of being seen as an edge
  // (the last stage still holds its reset value at the INIT load edge).
  assign d      = sync_q[SYNC_STAGES-1] ^ INV;
  assign d_next = sync_q[SYNC_STAGES-2] ^ INV;

  // Receiver FSM with registered level, pulses and edge counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_INIT;
      init_q   <= '0;
      x_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SCS8HD_BUFINV_RX_FILTER_EN
      glitch_q <= 1'b0;
      q_q      <= '0;
`endif
    end else begin
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
`ifdef SCS8HD_BUFINV_RX_FILTER_EN
      glitch_q <= 1'b0;
`endif
      case (state_q)
        ST_INIT: begin
          if (init_q == INIT_LAST) begin
            x_q     <= d_next;
            state_q <= ST_STABLE;
          end else begin
            init_q <= init_q + 2'd1;
          end
        end

        ST_STABLE: begin
          if (d != x_q) begin
`ifdef SCS8HD_BUFINV_RX_FILTER_EN
            if (FILT_CYCLES == 1) begin
              x_q    <= ~x_q;
              rise_q <= ~x_q;
              fall_q <= x_q;
              cnt_q  <= cnt_q + CW'(1);
              q_q    <= '0;
            end else begin
              q_q     <= 4'd1;
              state_q <= ST_QUAL;
            end
`else
            x_q    <= ~x_q;
            rise_q <= ~x_q;
            fall_q <= x_q;
            cnt_q  <= cnt_q + CW'(1);
`endif
          end
        end

`ifdef SCS8HD_BUFINV_RX_FILTER_EN
        ST_QUAL: begin
          if (d == x_q) begin
            // Line fell back before qualifying: abandon, X untouched
            glitch_q <= 1'b1;
            q_q      <= '0;
            state_q  <= ST_STABLE;
          end else if (q_q + 4'd1 == FILT_Q) begin
            x_q     <= ~x_q;
            rise_q  <= ~x_q;
            fall_q  <= x_q;
            cnt_q   <= cnt_q + CW'(1);
            q_q     <= '0;
            state_q <= ST_STABLE;
          end else begin
            q_q <= q_q + 4'd1;
          end
        end
`endif

        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign bus.X    = x_q;
  assign bus.RISE = rise_q;
  assign bus.FALL = fall_q;
  assign bus.CNT  = cnt_q;
`ifdef SCS8HD_BUFINV_RX_FILTER_EN
  assign bus.GLITCH = glitch_q;
`else
  assign bus.GLITCH = 1'b0;
`endif
  assign state_o  = state_q;

endmodule

// File: tb/tb_scs8hd_bufinv_rx.sv
// tb_scs8hd_bufinv_rx: two receivers on one line (INVERT=1/CW=8 and INVERT=0/CW=2),
// checked against a sample-history reference model with an event scoreboard.
module tb_scs8hd_bufinv_rx;

  localparam int S = 2;
  localparam int F = 4;
`ifdef SCS8HD_BUFINV_RX_FILTER_EN
  localparam int F_EFF = F;
`else
  localparam int F_EFF = 1;
`endif
  localparam int L = S + F_EFF - 1;   // edges from line change to accept
  localparam int W = 42;              // {cycle[31:0], kind[1:0], cnt[7:0]}

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET;
  logic a_drv;
  always #5 CLK = ~CLK;

  scs8hd_bufinv_rx_if #(.CW(8)) bus0 ();
  scs8hd_bufinv_rx_if #(.CW(2)) bus1 ();
  assign bus0.A = a_drv;
  assign bus1.A = a_drv;
  logic [1:0] state0, state1;

  scs8hd_bufinv_rx #(.SYNC_STAGES(S), .FILT_CYCLES(F), .CW(8), .INVERT(1)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(bus0.slave), .state_o(state0));
  scs8hd_bufinv_rx #(.SYNC_STAGES(S), .FILT_CYCLES(F), .CW(2), .INVERT(0)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus1.slave), .state_o(state1));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_rise0  = 0, n_fall0 = 0, n_glitch0 = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Level seen by the receiver at edge n after reset release is the line sampled
  // at edge n-S; a new level is taken after F_EFF consecutive differing samples,
  // a differing run that ends early is one glitch.
  bit samp[$];
  int rel_n;
  bit x_m[2], rise_m[2], fall_m[2], gl_m[2];
  int run_m[2], cnt_m[2];
  bit inv_m[2] = '{1'b1, 1'b0};

  always @(posedge CLK) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      rise_m[i] = 0; fall_m[i] = 0; gl_m[i] = 0;
    end
    if (RESET) begin
      rel_n = 0;
      samp.delete();
      for (int i = 0; i < 2; i++) begin
        x_m[i] = 0; run_m[i] = 0; cnt_m[i] = 0;
      end
    end else begin
      rel_n++;
      samp.push_back(a_drv);
      for (int i = 0; i < 2; i++) begin
        if (rel_n == S) begin
          x_m[i] = samp[0] ^ inv_m[i];
        end else if (rel_n > S) begin
          bit dv;
          dv = samp[rel_n - S - 1] ^ inv_m[i];
          if (dv != x_m[i]) begin
            run_m[i]++;
            if (run_m[i] >= F_EFF) begin
              x_m[i] = dv;
              rise_m[i] = dv;
              fall_m[i] = !dv;
              cnt_m[i]++;
              run_m[i] = 0;
            end
          end else if (run_m[i] > 0) begin
            gl_m[i] = 1;
            run_m[i] = 0;
          end
        end
      end
      if (rise_m[0] || fall_m[0] || gl_m[0]) begin
        logic [1:0] kind;
        kind = gl_m[0] ? 2'b11 : (rise_m[0] ? 2'b01 : 2'b10);
        exp_q.push_back({32'(cyc), kind, 8'(cnt_m[0])});
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [W-1:0] act;
    if (bus0.RISE) n_rise0++;
    if (bus0.FALL) n_fall0++;
    if (bus0.GLITCH) n_glitch0++;
    while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
      chk("missed_event_cycle", exp_q[0][W-1 -: 32], cyc);
      void'(exp_q.pop_front());
    end
    if (bus0.RISE || bus0.FALL || bus0.GLITCH) begin
      act = {32'(cyc), bus0.FALL | bus0.GLITCH, bus0.RISE | bus0.GLITCH, bus0.CNT};
      if (exp_q.size() == 0) chk("unexpected_event", act, 0);
      else chk("event", act, exp_q.pop_front());
    end
    chk("x0", bus0.X, x_m[0]);
    chk("cnt0", bus0.CNT, cnt_m[0] % 256);
    chk("x1", bus1.X, x_m[1]);
    chk("cnt1", bus1.CNT, cnt_m[1] % 4);
    chk("pulses1", {bus1.RISE, bus1.FALL, bus1.GLITCH}, {rise_m[1], fall_m[1], gl_m[1]});
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic drive_a(bit v, int hold);
    a_drv = v;
    wait_cyc(hold);
  endtask

  task automatic do_reset(int n);
    RESET = 1'b1;
    wait_cyc(n);
    RESET = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, f0, r0, g0;
    logic [7:0] c0;
    a_drv = 1'b0;
    RESET = 1'b1;
    wait_cyc(3);
    chk("reset_x", bus0.X, 0);
    chk("reset_cnt", bus0.CNT, 0);
    chk("reset_pulses", {bus0.RISE, bus0.FALL, bus0.GLITCH}, 0);
    chk("reset_state", state0, 0);
    RESET = 1'b0;

    // Startup with line low: X settles to 1 after S edges, no edge counted
    wait_cyc(S);
    chk("startup_x", bus0.X, 1);
    chk("startup_rise", bus0.RISE, 0);
    chk("startup_cnt", bus0.CNT, 0);
    chk("startup_rises_seen", n_rise0, 0);
    wait_cyc(3);

    // Clean edge: line 0->1, FALL expected L edges after edge k
    f0 = n_fall0;
    a_drv = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      wait_cyc(1);
      if (bus0.FALL && lat == 0) lat = i;
    end
    chk("fall_latency", lat, L + 1);
    chk("fall_count", n_fall0 - f0, 1);
    chk("clean_cnt", bus0.CNT, 1);
    chk("clean_x", bus0.X, 0);

    // Glitch: line back low, then high for 2 cycles
    drive_a(1'b0, 12);
    c0 = bus0.CNT;
    g0 = n_glitch0;
    r0 = n_rise0;
    drive_a(1'b1, 2);
    drive_a(1'b0, 14);
    chk("glitch_x", bus0.X, 1);
    chk("glitch_pulses", n_glitch0 - g0, (F_EFF > 2) ? 1 : 0);
    chk("glitch_cnt", bus0.CNT, c0 + ((F_EFF > 2) ? 0 : 2));
    chk("glitch_rises", n_rise0 - r0, (F_EFF > 2) ? 0 : 1);

    // Reset at edge k+3 of a 0->1 line change
    f0 = n_fall0;
    a_drv = 1'b1;
    wait_cyc(3);
    RESET = 1'b1;
    wait_cyc(1);
    chk("midq_state", state0, 0);
    chk("midq_cnt", bus0.CNT, 0);
    RESET = 1'b0;
    wait_cyc(12);
    chk("midq_falls", n_fall0 - f0, (L <= 2) ? 1 : 0);
    chk("midq_cnt_after", bus0.CNT, 0);
    chk("midq_x", bus0.X, 0);

    // Counter wrap on the CW=2 receiver: 5 qualified edges
    a_drv = 1'b0;
    do_reset(2);
    wait_cyc(8);
    for (int k = 1; k <= 5; k++) begin
      drive_a(!a_drv, 10);
      chk("cnt_wrap", bus1.CNT, k % 4);
    end

    // Single-cycle pulse on the line
    drive_a(1'b0, 10);
    r0 = n_rise0; f0 = n_fall0; g0 = n_glitch0;
    drive_a(1'b1, 1);
    drive_a(1'b0, 12);
    chk("pulse1_rise0", n_rise0 - r0, (F_EFF == 1) ? 1 : 0);
    chk("pulse1_fall0", n_fall0 - f0, (F_EFF == 1) ? 1 : 0);
    chk("pulse1_glitch0", n_glitch0 - g0, (F_EFF == 1) ? 0 : 1);

    // Randomized line activity with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 2));
      drive_a(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end

    wait_cyc(20);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
